// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, instruction size and
// the byte-PC to word-index conversion used by the fetch control logic.
package riscv_fetch_pkg;

  // Fetch runs until the program end is reached, then parks in HALT until a
  // redirect points it back at the program.
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;

  // Word index of a byte PC; callers truncate to their memory index width.
  function automatic logic [31:0] pc_to_index(input logic [31:0] byte_pc);
    return byte_pc >> 2;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Handshake bundle between the fetch controller and its neighbours: the
// downstream stall/redirect controls and the fetch-side results.
interface pc_fetch_ctrl_if #(
  parameter int unsigned IDX_W = 3
);
  logic             stall;
  logic             redirect;
  logic [31:0]      redirect_target;
  logic [IDX_W-1:0] pc_index;
  logic [31:0]      pc;
  logic [31:0]      instr_pc;
  logic             instr_valid;
  logic             halted;
  logic [31:0]      fetch_count;

  // Driven by the pipeline control (decode/execute side).
  modport master (
    output stall, redirect, redirect_target,
    input  pc_index, pc, instr_pc, instr_valid, halted, fetch_count
  );

  // Driven by the fetch controller.
  modport slave (
    input  stall, redirect, redirect_target,
    output pc_index, pc, instr_pc, instr_valid, halted, fetch_count
  );
endinterface

// File: rtl/fetch_valid_tracker.sv
// Alignment registers for the instruction memory's registered output: records
// which PC the memory is currently presenting and whether it is usable.
module fetch_valid_tracker (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,       // downstream holding a valid instruction
  input  logic        issue,      // a real fetch is being presented this cycle
  input  logic [31:0] issue_pc,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  // Track the PC sampled by memory; any non-issue, non-hold cycle is a bubble.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, matching real flip-flop behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (hold) begin
      instr_pc    <= instr_pc;
      instr_valid <= instr_valid;
    end else if (issue) begin
      instr_pc    <= issue_pc;
      instr_valid <= 1'b1;
    end else begin
      // Squash, end-of-program or halted: the memory output is a bubble and
      // instr_pc keeps its last delivered value.
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch control: drives the instruction memory word
// index, handles stall, redirect with squash, and halting at program end.
module pc_fetch_ctrl
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned PROG_WORDS = 7,
  parameter int unsigned IDX_W      = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_fetch_ctrl_if.slave bus
);

  localparam logic [31:0]      PC_LIMIT  = 32'(PROG_WORDS * INSTR_BYTES);
  localparam logic [IDX_W-1:0] CLAMP_IDX = IDX_W'(PROG_WORDS - 1);

  logic [31:0]  pc_q;
  fetch_state_e state_q;
  logic [31:0]  count_q;
  logic [31:0]  instr_pc;
  logic         instr_valid;
  logic         eff_stall;
  logic         in_range;
  logic         running;
  logic         issue;
  logic         hold;
  logic [31:0]  target_aligned;

  // A stall only matters when there is a valid instruction to hold.
  assign eff_stall      = bus.stall && instr_valid;
  assign in_range       = (pc_q < PC_LIMIT);
  assign running        = (state_q == RUN);
  assign target_aligned = bus.redirect_target & ~32'h3;

  // Redirect beats stall; a real fetch only issues from an in-range PC.
  assign hold  = running && !bus.redirect && eff_stall;
  assign issue = running && !bus.redirect && !eff_stall && in_range;

  // Word index to memory: re-read the held instruction, clamp out-of-range.
  // NOTE: the default assignment first guarantees no latch is inferred.
  always_comb begin
    bus.pc_index = IDX_W'(pc_to_index(pc_q));
    if (eff_stall) begin
      bus.pc_index = IDX_W'(pc_to_index(instr_pc));
    end else if (!in_range) begin
      bus.pc_index = CLAMP_IDX;
    end
  end

  // PC and run/halt state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.redirect) begin
            pc_q <= target_aligned;
          end else if (eff_stall) begin
            pc_q <= pc_q;
          end else if (in_range) begin
            pc_q <= pc_q + 32'(INSTR_BYTES);
          end else begin
            state_q <= HALT;
          end
        end
        HALT: begin
          if (bus.redirect) begin
            pc_q    <= target_aligned;
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Count instructions handed downstream; wraps modulo 2**32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (instr_valid && !bus.stall) begin
      count_q <= count_q + 32'd1;
    end
  end

  fetch_valid_tracker u_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold        (hold),
    .issue       (issue),
    .issue_pc    (pc_q),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

  assign bus.pc          = pc_q;
  assign bus.instr_pc    = instr_pc;
  assign bus.instr_valid = instr_valid;
  assign bus.halted      = (state_q == HALT);
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized
// stall/redirect traffic, all compared against a cycle-level reference model.
module tb_pc_fetch_ctrl;

  localparam int unsigned PROG_WORDS = 7;
  localparam int unsigned IDX_W      = 3;
  localparam logic [31:0] LIMIT      = 32'(PROG_WORDS * 4);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_ctrl_if #(.IDX_W(IDX_W)) bus ();

  pc_fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .PROG_WORDS (PROG_WORDS),
    .IDX_W      (IDX_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural view of the fetch stage.
  logic [31:0] m_pc, m_ipc, m_count;
  logic        m_valid, m_halted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_index(input logic s);
    if (s && m_valid)      return (m_ipc / 4) % (1 << IDX_W);
    else if (m_pc >= LIMIT) return PROG_WORDS - 1;
    else                   return (m_pc / 4) % (1 << IDX_W);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_count = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0;
  endtask

  // One clock edge of the fetch stage, written from the behavioural rules.
  task automatic model_edge(input logic s, input logic r, input logic [31:0] t);
    if (!m_halted) begin
      if (r) begin
        if (m_valid && !s) m_count++;
        m_pc = t & ~32'h3;
        m_valid = 1'b0;
      end else if (s && m_valid) begin
        // everything holds
      end else if (m_pc < LIMIT) begin
        if (m_valid) m_count++;
        m_ipc = m_pc;
        m_valid = 1'b1;
        m_pc = m_pc + 4;
      end else begin
        if (m_valid) m_count++;
        m_valid = 1'b0;
        m_halted = 1'b1;
      end
    end else if (r) begin
      m_pc = t & ~32'h3;
      m_halted = 1'b0;
    end
  endtask

  task automatic check_regs();
    check("pc", bus.pc, m_pc);
    check("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
    if (m_valid) check("instr_pc", bus.instr_pc, m_ipc);
    check("halted", 32'(bus.halted), 32'(m_halted));
    check("fetch_count", bus.fetch_count, m_count);
  endtask

  // Apply inputs just after a falling edge, check the combinational index,
  // take one rising edge, then check registered state on the falling edge.
  task automatic step(input logic s, input logic r, input logic [31:0] t);
    bus.stall = s; bus.redirect = r; bus.redirect_target = t;
    #1;
    check("pc_index", 32'(bus.pc_index), model_index(s));
    @(posedge clk);
    model_edge(s, r, t);
    @(negedge clk);
    check_regs();
  endtask

  task automatic do_reset();
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = '0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_pc", bus.pc, 32'h0);
    check("rst_instr_pc", bus.instr_pc, 32'h0);
    check("rst_valid", 32'(bus.instr_valid), 32'h0);
    check("rst_halted", 32'(bus.halted), 32'h0);
    check("rst_count", bus.fetch_count, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Free-run until the given instr_pc is valid, with a cycle budget.
  task automatic run_until_ipc(input logic [31:0] want, input string tag);
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_valid && bus.instr_pc == want) break;
      step(1'b0, 1'b0, '0);
    end
    check(tag, bus.instr_pc, want);
  endtask

  task automatic run_until_halt(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (bus.halted) break;
      step(1'b0, 1'b0, '0);
    end
    check(tag, 32'(bus.halted), 32'h1);
  endtask

  initial begin
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = '0;
    model_reset();
    @(negedge clk);

    // Free run after reset: 0,4,...,24 then halt with 7 delivered.
    do_reset();
    for (int i = 0; i < PROG_WORDS; i++) begin
      step(1'b0, 1'b0, '0);
      check("run_ipc", bus.instr_pc, 32'(i * 4));
      check("run_valid", 32'(bus.instr_valid), 32'h1);
    end
    step(1'b0, 1'b0, '0);
    check("end_valid", 32'(bus.instr_valid), 32'h0);
    check("end_halted", 32'(bus.halted), 32'h1);
    check("end_count", bus.fetch_count, 32'd7);
    step(1'b0, 1'b0, '0);
    check("halt_count", bus.fetch_count, 32'd7);

    // Stall three cycles while instr_pc=8.
    do_reset();
    run_until_ipc(32'h8, "reach_ipc8");
    for (int i = 0; i < 3; i++) begin
      logic [31:0] cnt_before;
      cnt_before = bus.fetch_count;
      bus.stall = 1'b1;
      #1;
      check("stall_index", 32'(bus.pc_index), 32'd2);
      step(1'b1, 1'b0, '0);
      check("stall_ipc", bus.instr_pc, 32'h8);
      check("stall_pc", bus.pc, 32'hC);
      check("stall_count", bus.fetch_count, cnt_before);
    end
    step(1'b0, 1'b0, '0);
    check("unstall_ipc", bus.instr_pc, 32'hC);

    // Redirect to 0x14 while instr_pc=4: fetch at 8 is squashed.
    do_reset();
    run_until_ipc(32'h4, "reach_ipc4");
    step(1'b0, 1'b1, 32'h14);
    check("redir_valid", 32'(bus.instr_valid), 32'h0);
    check("redir_pc", bus.pc, 32'h14);
    step(1'b0, 1'b0, '0);
    check("redir_ipc", bus.instr_pc, 32'h14);
    check("redir_valid2", 32'(bus.instr_valid), 32'h1);

    // Redirect and stall together: redirect wins (target low bits dropped).
    step(1'b1, 1'b1, 32'h0000_000B);
    check("rs_pc", bus.pc, 32'h8);
    check("rs_valid", 32'(bus.instr_valid), 32'h0);

    // From HALT: redirect to 0, then to 0x40 which halts again.
    run_until_halt("reach_halt");
    step(1'b0, 1'b1, 32'h0);
    check("unhalt", 32'(bus.halted), 32'h0);
    step(1'b0, 1'b0, '0);
    check("unhalt_ipc", bus.instr_pc, 32'h0);
    check("unhalt_valid", 32'(bus.instr_valid), 32'h1);
    step(1'b0, 1'b1, 32'h40);
    step(1'b0, 1'b0, '0);
    check("rehalt", 32'(bus.halted), 32'h1);
    check("rehalt_index_le6", 32'(bus.pc_index <= 3'd6), 32'h1);

    // Async reset mid-run at instr_pc=16, away from any clock edge.
    do_reset();
    run_until_ipc(32'h10, "reach_ipc16");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_pc", bus.pc, 32'h0);
    check("async_ipc", bus.instr_pc, 32'h0);
    check("async_valid", 32'(bus.instr_valid), 32'h0);
    check("async_count", bus.fetch_count, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, '0);
    check("restart_ipc", bus.instr_pc, 32'h0);
    check("restart_valid", 32'(bus.instr_valid), 32'h1);

    // Randomized stall/redirect traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic        s, r;
      logic [31:0] t;
      s = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 10);
      case ($urandom_range(0, 3))
        0:       t = $urandom();
        1:       t = 32'(LIMIT + $urandom_range(0, 16));
        default: t = $urandom_range(0, LIMIT - 1);
      endcase
      step(s, r, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
